fpu_addsub_arbiter: RTL and testbench
=====================================

// Module: fpu_addsub_arbiter
// PURPOSE
//  Shares one FP32 add/sub unit (exception block + adder pipeline) between NUM_REQ requesters.
//  Arbitrates round-robin, registers the winner's operands onto the unit's input bus, and tracks
//  the winner's tag through a fixed-latency shadow pipe. Returns the unit's result/exception
//  to that requester. A drain FSM quiesces the unit for reconfiguration or flush.
// PARAMETERS
//  WIDTH       32  operand/result width (FP32)
//  NUM_REQ     4   number of requesters, >=2
//  FU_LATENCY  1   cycles from fu_valid to fu_result/fu_exception valid, >=1
// PORTS
//  clk            in   1                clock
//  arst_n         in   1                async reset, active-low
//  req_valid      in   NUM_REQ          per-requester operation valid
//  req_ready      out  NUM_REQ          one-hot grant; handshake = valid & ready
//  req_a          in   NUM_REQ*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b          in   NUM_REQ*WIDTH    operand B, same packing
//  req_op         in   NUM_REQ          0 = add, 1 = sub (a - b)
//  fu_valid       out  1                issue strobe to the shared unit
//  fu_a, fu_b     out  WIDTH            issued operands
//  fu_op          out  1                issued operation_select
//  fu_result      in   WIDTH            unit result, FU_LATENCY after fu_valid
//  fu_exception   in   1                unit exception flag, same timing
//  rsp_valid      out  NUM_REQ          one-hot response pulse, no backpressure
//  rsp_result     out  WIDTH            response data
//  rsp_exception  out  1                response exception flag
//  drain_req      in   1                level; stop accepting and empty the pipe
//  drain_done     out  1                high while in DRAINED
//  busy           out  1                any op in flight (issue reg or tag pipe)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=RUN, rr pointer=0, tag pipe empty.
//  FSM RUN: req_ready = rr grant among req_valid. At most one bit set. Unit accepts every cycle.
//    RUN->DRAIN when drain_req=1. No grant in the cycle drain_req is first seen.
//  DRAIN: req_ready=0. ->DRAINED when busy=0.
//  DRAINED: drain_done=1, req_ready=0. ->RUN when drain_req=0 (grants resume next cycle).
//  Round-robin: search starts at pointer. On handshake by i, pointer <= (i+1) mod NUM_REQ.
//    Pointer holds when there is no handshake.
//  Issue: handshake in cycle T -> fu_valid=1, fu_a/fu_b/fu_op = winner's at T+1.
//    fu_valid=0 when there is no handshake. fu_a/fu_b hold their last value.
//  Tag pipe: FU_LATENCY-deep shift of {valid, id}, loaded at fu_valid.
//  Response: at T+1+FU_LATENCY the pipe head is valid. rsp_* are registered from fu_result/fu_exception.
//    rsp_valid[id]=1 at T+2+FU_LATENCY, one cycle only. Total latency = FU_LATENCY+2 cycles.
//  Throughput 1 op/cycle. Back-to-back grants to different requesters are allowed.
//  Responses return in issue order.
//  Simultaneous drain_req and pending req_valid: the drain wins and no grant is given.
//  Ops already in flight still complete and respond.
//  Async reset mid-operation discards in-flight ops. No rsp_valid is issued for them.
//  id width = $clog2(NUM_REQ). NUM_REQ not a power of two: pointer wraps at NUM_REQ-1 -> 0.
// CONFIGURATION
//  FPU_ARB_STATS_EN defined: adds outputs stat_grants [NUM_REQ*16] and stat_exc [16].
//    stat_grants: per-requester saturating grant counters.
//    stat_exc: saturating count of responses with rsp_exception=1.
//    Both counters reset to 0 and saturate at 16'hFFFF.
//  Undefined: these ports and counters do not exist. All other timing is identical.
// STRUCTURE
//  fpu_pkg: FP32 constants (EXP_BITS=8, MANT_BITS=23, CAN_NAN=32'h7FC00000, POS_INF=32'h7F800000),
//    arbiter state enum {RUN, DRAIN, DRAINED}.
//  Sub-module fpu_rr_arbiter: req vector + pointer -> one-hot grant and encoded id (combinational).
//  Top holds the FSM, the issue registers, the tag pipe and the response registers.
// TESTING
//  1 Single op: req0 a=3F800000 b=3F800000 op=0 -> fu_valid at T+1.
//    Model FU returns 40000000 -> rsp_valid=0001, rsp_result=40000000 at T+3 (FU_LATENCY=1).
//  2 All 4 requesters valid every cycle -> grants 0,1,2,3,0,... one per cycle.
//    rsp_valid order matches grant order. No starvation.
//  3 Exception path: req2 a=7F800000 b=7F800000 op=1; FU returns 7FC00000, exc=1
//    -> rsp_valid=0100, rsp_exception=1, rsp_result=7FC00000.
//  4 drain_req raised with 2 ops in flight -> no new grant.
//    Both responses delivered, then drain_done=1 and busy=0.
//    drain_req=0 -> grants resume next cycle.
//  5 arst_n low with 1 op in flight -> all outputs 0.
//    No rsp_valid after release. Next grant goes to requester 0.
//  6 FU_LATENCY=3, NUM_REQ=3 build: latency 5 cycles, pointer wraps 2->0.
//    With FPU_ARB_STATS_EN: stat_grants match the issued counts.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FP32 constants and arbiter state type shared by the add/sub arbiter
package fpu_pkg;

  localparam int          EXP_BITS  = 8;
  localparam int          MANT_BITS = 23;
  localparam logic [31:0] CAN_NAN   = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin pick: request vector + pointer -> one-hot grant and id
module fpu_rr_arbiter
  import fpu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_id,
  output logic               o_any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  // Walk the requesters starting at the pointer, wrapping at NUM_REQ-1, and take the first one set
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin sharing of one FP32 add/sub unit; optional stats via FPU_ARB_STATS_EN
module fpu_addsub_arbiter
  import fpu_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int NUM_REQ    = 4,
  parameter  int FU_LATENCY = 1,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic                     fu_valid,
  output logic [WIDTH-1:0]         fu_a,
  output logic [WIDTH-1:0]         fu_b,
  output logic                     fu_op,
  input  logic [WIDTH-1:0]         fu_result,
  input  logic                     fu_exception,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_exception,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    stat_grants,
  output logic [15:0]              stat_exc
`endif
);

  arb_state_e             r_state;
  logic                   r_drain_done;
  logic [IDW-1:0]         r_ptr;

  logic                   r_fu_valid;
  logic [WIDTH-1:0]       r_fu_a;
  logic [WIDTH-1:0]       r_fu_b;
  logic                   r_fu_op;
  logic [IDW-1:0]         r_fu_id;

  logic [FU_LATENCY-1:0]  r_tag_v;
  logic [IDW-1:0]         r_tag_id [FU_LATENCY];

  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [WIDTH-1:0]       r_rsp_result;
  logic                   r_rsp_exception;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDW-1:0]         w_id;
  logic                   w_any;
  logic                   w_accept;
  logic                   w_hs;
  logic                   w_busy;
  logic                   w_head_v;
  logic [IDW-1:0]         w_head_id;
  logic [WIDTH-1:0]       w_sel_a;
  logic [WIDTH-1:0]       w_sel_b;
  logic                   w_sel_op;

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  // Grants only in RUN, and a fresh drain request blocks the grant in the same cycle
  assign w_accept  = (r_state == RUN) && !drain_req;
  assign req_ready = w_accept ? w_grant : '0;
  assign w_hs      = w_accept && w_any;

  assign w_busy    = r_fu_valid || (|r_tag_v);
  assign w_head_v  = r_tag_v[FU_LATENCY-1];
  assign w_head_id = r_tag_id[FU_LATENCY-1];

  // Select the winner's operands from the packed request buses
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_id == IDW'(i)) begin
        w_sel_a  = req_a[i*WIDTH +: WIDTH];
        w_sel_b  = req_b[i*WIDTH +: WIDTH];
        w_sel_op = req_op[i];
      end
    end
  end

  // Drain FSM: RUN -> DRAIN on request, DRAIN -> DRAINED once nothing is in flight, back on release
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= RUN;
      r_drain_done <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (drain_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_busy) begin
            r_state      <= DRAINED;
            r_drain_done <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            r_state      <= RUN;
            r_drain_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= RUN;
          r_drain_done <= 1'b0;
        end
      endcase
    end
  end

  // Round-robin pointer moves past the winner on every handshake and holds otherwise
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_id == IDW'(NUM_REQ-1)) ? '0 : w_id + 1'b1;
    end
  end

  // Issue register: strobe follows the handshake, operands hold between issues
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_fu_valid <= 1'b0;
      r_fu_a     <= '0;
      r_fu_b     <= '0;
      r_fu_op    <= 1'b0;
      r_fu_id    <= '0;
    end else begin
      r_fu_valid <= w_hs;
      if (w_hs) begin
        r_fu_a  <= w_sel_a;
        r_fu_b  <= w_sel_b;
        r_fu_op <= w_sel_op;
        r_fu_id <= w_id;
      end
    end
  end

  // Shadow tag pipe tracks which requester owns each op inside the unit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_tag_v <= '0;
      for (int k = 0; k < FU_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_v[0]  <= r_fu_valid;
      r_tag_id[0] <= r_fu_id;
      for (int k = 1; k < FU_LATENCY; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // Capture the unit's output when the pipe head is valid and pulse the owner's response bit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rsp_valid     <= '0;
      r_rsp_result    <= '0;
      r_rsp_exception <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= w_head_v && (w_head_id == IDW'(i));
      end
      if (w_head_v) begin
        r_rsp_result    <= fu_result;
        r_rsp_exception <= fu_exception;
      end
    end
  end

  assign fu_valid      = r_fu_valid;
  assign fu_a          = r_fu_a;
  assign fu_b          = r_fu_b;
  assign fu_op         = r_fu_op;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_exception = r_rsp_exception;
  assign drain_done    = r_drain_done;
  assign busy          = w_busy;

`ifdef FPU_ARB_STATS_EN
  logic [15:0] r_stat_g [NUM_REQ];
  logic [15:0] r_stat_exc;

  // Saturating per-requester grant counters and exception-response counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat_g[i] <= '0;
      r_stat_exc <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_hs && (w_id == IDW'(i)) && (r_stat_g[i] != 16'hFFFF)) begin
          r_stat_g[i] <= r_stat_g[i] + 16'd1;
        end
      end
      if (w_head_v && fu_exception && (r_stat_exc != 16'hFFFF)) begin
        r_stat_exc <= r_stat_exc + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*16 +: 16] = r_stat_g[i];
  end
  assign stat_exc = r_stat_exc;
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - self-checking bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 1;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_op;
  logic           fu_valid;
  logic [W-1:0]   fu_a;
  logic [W-1:0]   fu_b;
  logic           fu_op;
  logic [W-1:0]   fu_result;
  logic           fu_exception;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_exception;
  logic           drain_req;
  logic           drain_done;
  logic           busy;
`ifdef FPU_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_exc;
`endif

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.WIDTH(W), .NUM_REQ(N), .FU_LATENCY(L)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .fu_valid      (fu_valid),
    .fu_a          (fu_a),
    .fu_b          (fu_b),
    .fu_op         (fu_op),
    .fu_result     (fu_result),
    .fu_exception  (fu_exception),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_exception (rsp_exception),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy          (busy)
`ifdef FPU_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_exc      (stat_exc)
`endif
  );

  // Stand-in FP unit: a few exact FP32 results, integer arithmetic otherwise; exc on Inf/NaN exponent
  function automatic logic [32:0] fu_f(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] r;
    if (a == 32'h7F800000 && b == 32'h7F800000 && op) return {1'b1, 32'h7FC00000};
    if (a == 32'h3F800000 && b == 32'h3F800000 && !op) return {1'b0, 32'h40000000};
    if (a == 32'h40400000 && b == 32'h3F800000 && op) return {1'b0, 32'h40000000};
    if (a == 32'h40000000 && b == 32'h40000000 && !op) return {1'b0, 32'h40800000};
    r = op ? a - b : a + b;
    return {((&a[30:23]) | (&b[30:23])), r};
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fu_result    <= '0;
      fu_exception <= 1'b0;
    end else if (fu_valid) begin
      {fu_exception, fu_result} <= fu_f(fu_a, fu_b, fu_op);
    end
  end

  logic [31:0] ta [N];
  logic [31:0] tb_ [N];
  logic        top_ [N];

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb_[i];
      req_op[i]       = top_[i];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        exc;
    longint      due;
  } rsp_t;

  rsp_t        q[$];
  longint      cyc = 0;
  int          m_ptr = 0;
  bit          accept_en = 1'b1;
  bit          mon_en = 1'b0;
  int          m_grants [N];
  int          m_exc = 0;
  bit          fx_v = 1'b0;
  logic [31:0] fx_a, fx_b;
  logic        fx_op;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: round-robin from the spec's rules, issue one cycle later, response L+2 after grant
  always @(negedge clk) begin
    if (mon_en && arst_n) begin
      int          gid;
      logic [N-1:0] eg;
      logic [32:0]  fr;
      chk("fu_valid", 64'(fu_valid), 64'(fx_v));
      if (fx_v) begin
        chk("fu_a", 64'(fu_a), 64'(fx_a));
        chk("fu_b", 64'(fu_b), 64'(fx_b));
        chk("fu_op", 64'(fu_op), 64'(fx_op));
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        eg = N'(1) << q[0].id;
        chk("rsp_valid", 64'(rsp_valid), 64'(eg));
        chk("rsp_result", 64'(rsp_result), 64'(q[0].res));
        chk("rsp_exception", 64'(rsp_exception), 64'(q[0].exc));
        if (q[0].exc) m_exc++;
        void'(q.pop_front());
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
      end
      gid = -1;
      if (accept_en && !drain_req) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      eg = (gid >= 0) ? (N'(1) << gid) : '0;
      chk("req_ready", 64'(req_ready), 64'(eg));
      fx_v = (gid >= 0);
      if (gid >= 0) begin
        rsp_t r;
        fx_a  = ta[gid];
        fx_b  = tb_[gid];
        fx_op = top_[gid];
        fr    = fu_f(ta[gid], tb_[gid], top_[gid]);
        r.id  = gid;
        r.res = fr[31:0];
        r.exc = fr[32];
        r.due = cyc + 2 + L;
        q.push_back(r);
        m_ptr = (gid + 1) % N;
        m_grants[gid]++;
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_fu_valid"}, 64'(fu_valid), 64'(0));
    chk({tag, "_fu_a"}, 64'(fu_a), 64'(0));
    chk({tag, "_fu_b"}, 64'(fu_b), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
    chk({tag, "_rsp_exc"}, 64'(rsp_exception), 64'(0));
    chk({tag, "_drain_done"}, 64'(drain_done), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    vec_t tbl [4];
    bit   seen;
    tbl[0] = '{0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0};
    tbl[1] = '{2, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1};
    tbl[2] = '{1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
    tbl[3] = '{3, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0};

    arst_n    = 1'b0;
    req_valid = '0;
    drain_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0; tb_[i] = '0; top_[i] = 1'b0; m_grants[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    arst_n = 1'b1;
    mon_en = 1'b1;

    // Directed single operations with known results
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      ta[tbl[v].id]   = tbl[v].a;
      tb_[tbl[v].id]  = tbl[v].b;
      top_[tbl[v].id] = tbl[v].op;
      req_valid       = N'(1) << tbl[v].id;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_rsp_valid", 64'(rsp_valid), 64'(N'(1) << tbl[v].id));
      chk("tbl_rsp_result", 64'(rsp_result), 64'(tbl[v].res));
      chk("tbl_rsp_exc", 64'(rsp_exception), 64'(tbl[v].exc));
    end

    // All requesters valid continuously
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      ta[i] = 32'h1000 * (i + 1); tb_[i] = 32'h10 + i; top_[i] = i[0];
    end
    req_valid = '1;
    repeat (12) @(posedge clk);
    #1;
    req_valid = '0;

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        ta[i]   = $urandom;
        tb_[i]  = $urandom;
        top_[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("random_drained_queue", 64'(q.size()), 64'(0));

    // Drain with two ops in flight
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '1;
    drain_req = 1'b1;
    accept_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (drain_done) seen = 1'b1;
    end
    chk("drain_done", 64'(seen), 64'(1));
    chk("drain_busy", 64'(busy), 64'(0));
    chk("drain_queue_empty", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
    drain_req = 1'b0;
    @(posedge clk); #1;
    accept_en = 1'b1;
    chk("drain_released", 64'(drain_done), 64'(0));
    @(negedge clk);
    chk("resume_grant_any", 64'(|req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;

    // Async reset with one op in flight
    req_valid = '1;
    @(posedge clk); #1;
    req_valid = '0;
    arst_n    = 1'b0;
    mon_en    = 1'b0;
    q.delete();
    m_ptr = 0;
    fx_v  = 1'b0;
    m_exc = 0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    chk("post_reset_grant", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(q.size()), 64'(0));
`ifdef FPU_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(m_grants[i]));
    end
    chk("stat_exc", 64'(stat_exc), 64'(m_exc));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
